// File: rtl/fifo_1r1w_hs_if.sv
// Producer/consumer handshake bundle for fifo_1r1w_hs; the slave modport is the FIFO side.
interface fifo_1r1w_hs_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 32
);
  localparam int CWIDTH = $clog2(DEPTH + 1);

  logic              i_flush;
  logic              i_wvalid;
  logic              o_wready;
  logic [DWIDTH-1:0] i_wdata;
  logic              o_rvalid;
  logic              i_rready;
  logic [DWIDTH-1:0] o_rdata;
  logic [CWIDTH-1:0] o_count;
  logic              o_almost_full;
  logic              o_almost_empty;

  modport slave (
    input  i_flush, i_wvalid, i_wdata, i_rready,
    output o_wready, o_rvalid, o_rdata, o_count, o_almost_full, o_almost_empty
  );

  modport master (
    output i_flush, i_wvalid, i_wdata, i_rready,
    input  o_wready, o_rvalid, o_rdata, o_count, o_almost_full, o_almost_empty
  );
endinterface

// File: rtl/fifo_1r1w_hs.sv
// Synchronous valid/ready FIFO with an explicit occupancy count and a registered
// first-word-fall-through output stage fed from a RAM-style array.
module fifo_1r1w_hs #(
  parameter int DWIDTH        = 32,
  parameter int DEPTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  fifo_1r1w_hs_if.slave bus
);
  localparam int CWIDTH = $clog2(DEPTH + 1);
  localparam int IWIDTH = $clog2(DEPTH);
  localparam logic [CWIDTH-1:0] DEPTH_C  = CWIDTH'(DEPTH);
  localparam logic [CWIDTH-1:0] AFULL_C  = CWIDTH'(AFULL_THRESH);
  localparam logic [CWIDTH-1:0] AEMPTY_C = CWIDTH'(AEMPTY_THRESH);
  localparam logic [IWIDTH-1:0] LAST_IDX = IWIDTH'(DEPTH - 1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [IWIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [IWIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic              rvalid_q, rvalid_d;
  logic [DWIDTH-1:0] rdata_q;
  logic              wready, push, pop, issue;

  function automatic logic [IWIDTH-1:0] next_idx(input logic [IWIDTH-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  assign wready = !i_rst && !bus.i_flush && (count_q < DEPTH_C);
  assign push   = bus.i_wvalid && wready;
  assign pop    = rvalid_q && bus.i_rready;
  // The array holds count minus the word parked in the output register.
  assign issue  = !i_rst && !bus.i_flush && (count_q > CWIDTH'(rvalid_q))
                  && (!rvalid_q || bus.i_rready);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    rvalid_d = rvalid_q;
    if (bus.i_flush) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
      rvalid_d = 1'b0;
    end else begin
      if (push)  wr_idx_d = next_idx(wr_idx_q);
      if (issue) rd_idx_d = next_idx(rd_idx_q);
      if (issue)    rvalid_d = 1'b1;
      else if (pop) rvalid_d = 1'b0;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
    end
  end

  // NOTE: storage has no reset so it maps onto block RAM; count and valid qualify it.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_idx_q] <= bus.i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)      rdata_q <= '0;
    else if (issue) rdata_q <= mem[rd_idx_q];
  end

  assign bus.o_wready       = wready;
  assign bus.o_rvalid       = rvalid_q;
  assign bus.o_rdata        = rdata_q;
  assign bus.o_count        = count_q;
  assign bus.o_almost_full  = (count_q >= AFULL_C);
  assign bus.o_almost_empty = (count_q <= AEMPTY_C);

`ifndef SYNTHESIS
  logic              stall_q;
  logic [DWIDTH-1:0] rdata_prev_q;

  always_ff @(posedge i_clk) begin
    stall_q      <= !i_rst && rvalid_q && !bus.i_rready;
    rdata_prev_q <= rdata_q;
    assert (AFULL_THRESH >= 1 && AFULL_THRESH <= DEPTH);
    assert (AEMPTY_THRESH >= 0 && AEMPTY_THRESH < DEPTH);
    if (!i_rst) begin
      assert (count_q <= DEPTH_C);
      assert (wr_idx_q <= LAST_IDX && rd_idx_q <= LAST_IDX);
      assert (!rvalid_q || count_q != '0);
      assert (!stall_q || rdata_q == rdata_prev_q);
    end
  end
`endif
endmodule

// File: doc/fifo_1r1w_hs.md
# fifo_1r1w_hs

Parametrised synchronous FIFO with valid/ready handshakes on both ports, full DEPTH utilisation, an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. Storage is a BRAM-friendly array with a 1-cycle registered read. The read register acts as a first-word-fall-through output stage, so the consumer sees data and `o_rvalid` without popping first. It is the drop-in successor for queues between pipeline stages and bus adapters, where push-while-full and pop-while-empty must be impossible by construction.

## Interface
- `DWIDTH`, 32: data width in bits; ≥1.
- `DEPTH`, 32: total capacity in words, including the output register; ≥2; need not be a power of 2.
- `AFULL_THRESH`, DEPTH-4: `o_almost_full` asserts when count ≥ this value; range 1..DEPTH.
- `AEMPTY_THRESH`, 4: `o_almost_empty` asserts when count ≤ this value; range 0..DEPTH-1.
- `CWIDTH` (localparam): $clog2(DEPTH+1).
- `i_clk`  in  1  sole clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_flush`  in  1  synchronous discard of all contents.
- `i_wvalid`  in  1  producer has data.
- `o_wready`  out  1  FIFO can accept a word.
- `i_wdata`  in  DWIDTH  write data.
- `o_rvalid`  out  1  `o_rdata` holds the oldest word.
- `i_rready`  in  1  consumer takes the word.
- `o_rdata`  out  DWIDTH  oldest word (registered).
- `o_count`  out  CWIDTH  words held: array contents plus the output register.
- `o_almost_full`  out  1  count ≥ AFULL_THRESH.
- `o_almost_empty`  out  1  count ≤ AEMPTY_THRESH.

## Operation
- Push = `i_wvalid & o_wready`. Pop = `o_rvalid & i_rready`. No other event changes contents.
- `o_wready` = !i_rst & !i_flush & (count < DEPTH). It is combinational from registered state and is independent of `i_rready`, so there is no pop-to-push bypass when full.
- The array holds at most DEPTH words. A push writes `mem[wr_idx]`, and `wr_idx` wraps DEPTH-1 → 0.
- Read issue = array non-empty & (!o_rvalid | i_rready).
  - On issue, `o_rdata <= mem[rd_idx]` at the edge, `o_rvalid <= 1`, and `rd_idx` advances with the same wrap rule.
  - If there is a pop and no issue, `o_rvalid <= 0`.
- While `o_rvalid` = 0 or no pop occurs, `o_rdata` holds its value.
- count_next = count + push − pop. It is tracked explicitly, so full and empty never depend on a pointer compare and all DEPTH slots are usable.
- The array write and the read issue to the same index in the same cycle cannot occur: issue requires the array to be non-empty before the edge.
- Flush: at the edge where `i_flush` = 1, the indices, count and `o_rvalid` all go to 0. Any pop offered that cycle is discarded, and `o_rdata` is held.
- Reset (`i_rst` = 1 at an edge): indices and count go to 0, `o_rvalid` = 0, `o_rdata` = 0. Resetting mid-transfer drops all contents. `i_rst` takes priority over `i_flush`.
- Almost flags are combinational compares of registered count against the thresholds.
- Simulation assertions:
  - count ≤ DEPTH.
  - Indices < DEPTH.
  - Threshold ranges are legal.
  - `o_rvalid` = 1 implies count ≥ 1.
  - `o_rdata` is stable while `o_rvalid & !i_rready`.

## Timing
- Reset values: `o_rvalid` 0, `o_rdata` 0, `o_count` 0, `o_almost_empty` 1, `o_almost_full` 0.
- `o_wready` is 0 while `i_rst` = 1 and equals 1 in the first cycle after `i_rst` deasserts.
- Empty-FIFO latency: a push at edge N gives a read issue in cycle N+1. `o_rvalid` = 1 and the data are visible after edge N+1, i.e. 2 cycles.
- Streaming: with `i_wvalid` and `i_rready` held high, throughput is 1 word/cycle with a steady count of 2.
- Full: after DEPTH pushes with no pops, `o_wready` = 0. One pop re-asserts `o_wready` after that edge.
- A simultaneous push and pop leaves count unchanged; at count = DEPTH, push is blocked in that cycle.
- Flags and `o_count` update one edge after the causing handshake.

## Test plan
- **Reset:** hold `i_rst` 3 cycles with random inputs → all outputs at reset values and no push accepted. Release → `o_wready` = 1, `o_count` = 0.
- **Basic:** DEPTH=5, push 0xA1, 0xB2, 0xC3 back-to-back with `i_rready` = 0 → `o_rvalid` rises 2 cycles after the first push with `o_rdata` = 0xA1, `o_count` = 3. Pop three → 0xA1, 0xB2, 0xC3 in order, then `o_rvalid` = 0.
- **Full/wrap (DEPTH=5):**
  - Push 5 words → `o_wready` = 0, `o_almost_full` = 1 (AFULL_THRESH=4).
  - With `i_wvalid` held high, the 6th word is not accepted.
  - Pop 1 and push 1 repeatedly for 20 cycles → data order preserved across index wrap, count oscillates 4/5.
- **Streaming:** DEPTH=32, `i_wvalid` = `i_rready` = 1 for 100 cycles with an incrementing pattern → `o_rdata` increments every cycle after a 2-cycle fill, `o_count` = 2.
- **Flush:** with 7 words held and `i_rready` = 1, pulse `i_flush` → next cycle `o_count` = 0, `o_rvalid` = 0, `o_almost_empty` = 1. The word pushed after the flush is the next popped.
- **Backpressure:** random `i_wvalid`/`i_rready` for 10k cycles against a reference queue → no loss, duplication or reorder, `o_count` always matches the model, and `o_rdata` stays stable during stalls.
